// File: rtl/axi_lite_sram.sv
// AXI4-lite slave memory model serving instruction fetch and LSU traffic.
// Read and write channels run independent FSMs with programmable response latency.
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int unsigned ABITS       = DEPTH_LOG2 + 3;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // ---------------- read channel ----------------
  rd_state_t             rd_state, rd_next;
  logic [3:0]            rd_cnt;
  logic [31:0]           rd_addr_q, rd_offs;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_hit, ar_hs, r_hs, rd_fire;

  always_comb begin
    ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    r_hs    = S_AXI_RVALID & S_AXI_RREADY;
    rd_offs = rd_addr_q - BASE_ADDR;
    rd_hit  = (rd_offs >> ABITS) == '0;
    rd_idx  = rd_offs[ABITS-1:3];
    rd_fire = 1'b0;
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_WAIT;
      RD_WAIT: if (rd_cnt == '0) begin
        rd_fire = 1'b1;
        rd_next = RD_RESP;
      end
      RD_RESP: if (r_hs) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state      <= RD_IDLE;
      rd_cnt        <= '0;
      rd_addr_q     <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      rd_state      <= rd_next;
      S_AXI_ARREADY <= (rd_next == RD_IDLE);
      if (ar_hs) begin
        rd_addr_q <= S_AXI_ARADDR;
        rd_cnt    <= 4'(RD_LAT - 1);
      end else if (rd_state == RD_WAIT && rd_cnt != '0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      // Addressed 32-bit half is always returned in RDATA[31:0]
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RRESP  <= rd_hit ? RESP_OKAY : RESP_DECERR;
        if (!rd_hit)
          S_AXI_RDATA <= '0;
        else if (rd_offs[2])
          S_AXI_RDATA <= {32'h0, mem[rd_idx][63:32]};
        else
          S_AXI_RDATA <= {32'h0, mem[rd_idx][31:0]};
      end else if (r_hs) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_t             wr_state, wr_next;
  logic [3:0]            wr_cnt;
  logic [31:0]           wr_addr_q, wr_offs;
  logic [63:0]           wr_data_q;
  logic [7:0]            wr_strb_q;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_hit, aw_hs, w_hs, b_hs, aw_have, w_have, aw_done, w_done;
  logic                  wr_fire, wr_commit;

  always_comb begin
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    b_hs      = S_AXI_BVALID & S_AXI_BREADY;
    aw_have   = aw_done | aw_hs;
    w_have    = w_done | w_hs;
    wr_offs   = wr_addr_q - BASE_ADDR;
    wr_hit    = (wr_offs >> ABITS) == '0;
    wr_idx    = wr_offs[ABITS-1:3];
    wr_fire   = 1'b0;
    wr_next   = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_have && w_have) wr_next = WR_WAIT;
      WR_WAIT: if (wr_cnt == '0) begin
        wr_fire = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: if (b_hs) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
    wr_commit = wr_fire & wr_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state      <= WR_IDLE;
      wr_cnt        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      // AW and W are collected independently; each READY drops after its own beat
      aw_done       <= (wr_next == WR_IDLE) & aw_have;
      w_done        <= (wr_next == WR_IDLE) & w_have;
      S_AXI_AWREADY <= (wr_next == WR_IDLE) & ~aw_have;
      S_AXI_WREADY  <= (wr_next == WR_IDLE) & ~w_have;
      if (aw_hs) wr_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wr_data_q <= S_AXI_WDATA;
        wr_strb_q <= S_AXI_WSTRB;
      end
      if (wr_state == WR_IDLE && wr_next == WR_WAIT)
        wr_cnt <= 4'(WR_LAT - 1);
      else if (wr_state == WR_WAIT && wr_cnt != '0)
        wr_cnt <= wr_cnt - 4'd1;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_hit ? RESP_OKAY : RESP_DECERR;
      end else if (b_hs) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Array is never reset; a read sampling the same word this cycle sees old data
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int unsigned i = 0; i < 8; i++)
        if (wr_strb_q[i]) mem[wr_idx][8*i +: 8] <= wr_data_q[8*i +: 8];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_offs[1:0], wr_offs[2:0]};

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: vector table, scoreboard queues and
// hand-timed sequences for stall, ordering, collision and mid-transaction reset.
module tb_axi_lite_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic [2:0]  prot;
  logic [31:0] awaddr, araddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]  a_bresp, a_rresp;
  logic [63:0] a_rdata;
  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]  b_bresp, b_rresp;
  logic [63:0] b_rdata;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  assign awready = sel ? b_awready : a_awready;
  assign wready  = sel ? b_wready  : a_wready;
  assign bvalid  = sel ? b_bvalid  : a_bvalid;
  assign bresp   = sel ? b_bresp   : a_bresp;
  assign arready = sel ? b_arready : a_arready;
  assign rvalid  = sel ? b_rvalid  : a_rvalid;
  assign rresp   = sel ? b_rresp   : a_rresp;
  assign rdata   = sel ? b_rdata   : a_rdata;

  axi_lite_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(16), .RD_LAT(1), .WR_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid & ~sel),
    .S_AXI_AWREADY(a_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & ~sel),
    .S_AXI_WREADY(a_wready),
    .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready & ~sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid & ~sel),
    .S_AXI_ARREADY(a_arready),
    .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid),
    .S_AXI_RREADY(rready & ~sel)
  );

  axi_lite_sram #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(16), .RD_LAT(3), .WR_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid & sel),
    .S_AXI_AWREADY(b_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & sel),
    .S_AXI_WREADY(b_wready),
    .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready & sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid & sel),
    .S_AXI_ARREADY(b_arready),
    .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid),
    .S_AXI_RREADY(rready & sel)
  );

  int tests = 0;
  int fails = 0;
  logic [65:0] rd_q[$];
  logic [1:0]  b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, required handshake within 50 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every R/B handshake on the selected DUT pops one expectation
  always @(negedge clk) begin : mon_r
    logic [65:0] e;
    if (rvalid && rready) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_r: got rdata %h rresp %0d, required no response", rdata, rresp);
      end else begin
        e = rd_q.pop_front();
        check("r_data", rdata, e[63:0]);
        check("r_resp", 64'(rresp), 64'(e[65:64]));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [1:0] e;
    if (bvalid && bready) begin
      if (b_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_b: got bresp %0d, required no response", bresp);
      end else begin
        e = b_q.pop_front();
        check("b_resp", 64'(bresp), 64'(e));
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [63:0] ed, input logic [1:0] er,
                         output int lat);
    int n;
    lat = -1;
    rd_q.push_back({er, ed});
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin timeout("ar_wait"); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    if (!rvalid) begin timeout("r_wait"); return; end
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input logic [1:0] er, output int lat);
    logic aw_go, w_go;
    int n;
    lat = -1;
    b_q.push_back(er);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick(); n++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin timeout("aw_w_wait"); awvalid = 1'b0; wvalid = 1'b0; return; end
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    if (!bvalid) begin timeout("b_wait"); return; end
    tick();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  function automatic vec_t wv(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                              input logic [1:0] r);
    vec_t v;
    v = '{1'b1, a, d, s, 64'h0, r};
    return v;
  endfunction

  function automatic vec_t rv(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
    vec_t v;
    v = '{1'b0, a, 64'h0, 8'h00, d, r};
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = wv(32'h8000_0000, 64'h0000_0013_0000_0093, 8'hFF, 2'b00);
    vecs[1]  = rv(32'h8000_0000, 64'h0000_0093, 2'b00);
    vecs[2]  = rv(32'h8000_0004, 64'h0000_0013, 2'b00);
    vecs[3]  = rv(32'h8000_0006, 64'h0000_0013, 2'b00);
    vecs[4]  = wv(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
    vecs[5]  = wv(32'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 2'b00);
    vecs[6]  = rv(32'h8000_0008, 64'h5566_7788, 2'b00);
    vecs[7]  = rv(32'h8000_000C, 64'h1122_3344, 2'b00);
    vecs[8]  = rv(32'h7FFF_FFF8, 64'h0, 2'b11);
    vecs[9]  = wv(32'h8008_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b11);
    vecs[10] = rv(32'h8008_0000, 64'h0, 2'b11);
    vecs[11] = rv(32'h8000_0000, 64'h0000_0093, 2'b00);
    vecs[12] = wv(32'h8007_FFF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 2'b00);
    vecs[13] = rv(32'h8007_FFFC, 64'hCAFE_F00D, 2'b00);
    vecs[14] = rv(32'h8007_FFF8, 64'h1234_5678, 2'b00);
    vecs[15] = wv(32'h8000_0028, 64'h5555_5555_0000_0005, 8'hFF, 2'b00);
    vecs[16] = wv(32'h8000_0030, 64'h0000_0000_0000_0066, 8'hFF, 2'b00);

    prot = 3'b000; sel = 1'b0; rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;

    // reset state
    repeat (3) tick();
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_wready",  64'(wready),  64'(0));
    check("rst_rvalid",  64'(rvalid),  64'(0));
    check("rst_bvalid",  64'(bvalid),  64'(0));
    check("rst_rdata",   rdata,        64'h0);
    check("rst_resps",   64'({rresp, bresp}), 64'(0));
    rst_n = 1'b1;
    tick();
    check("rel_readies", 64'({arready, awready, wready}), 64'(3'b111));

    // vector table on DUT A (RD_LAT=1, WR_LAT=2)
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, lat);
        check($sformatf("vec%0d_wr_lat", i), 64'(lat), 64'(2));
      end else begin
        do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, lat);
        check($sformatf("vec%0d_rd_lat", i), 64'(lat), 64'(1));
      end
    end

    // W two cycles ahead of AW, partial strobe
    b_q.push_back(2'b00);
    awaddr = 32'h8000_0008; wdata = '1; wstrb = 8'h0F; wvalid = 1'b1; bready = 1'b1;
    check("wfirst_wready", 64'(wready), 64'(1));
    tick();
    wvalid = 1'b0;
    check("wfirst_ready_split", 64'({awready, wready}), 64'(2'b10));
    tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    check("wfirst_b_lat", 64'(lat), 64'(2));
    tick();
    check("wfirst_readies_back", 64'({awready, wready}), 64'(2'b11));
    do_read(32'h8000_0008, 64'hFFFF_FFFF, 2'b00, lat);
    do_read(32'h8000_000C, 64'h1122_3344, 2'b00, lat);

    // same-cycle commit and sample of word 5
    rd_q.push_back({2'b00, 64'h0000_0005});
    b_q.push_back(2'b00);
    awaddr = 32'h8000_0028; wdata = 64'h0000_0000_0000_0A05; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8000_0028; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    check("collide_valids", 64'({rvalid, bvalid}), 64'(2'b11));
    tick();
    do_read(32'h8000_0028, 64'h0000_0A05, 2'b00, lat);

    // DUT B: RD_LAT=3 with RREADY stalled
    sel = 1'b1;
    tick();
    do_write(32'h8000_0010, 64'h0BAD_F00D_8765_4321, 8'hFF, 2'b00, lat);
    check("b_wr_lat", 64'(lat), 64'(1));
    rd_q.push_back({2'b00, 64'h8765_4321});
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
    lat = 0;
    while (!arready && lat < 50) begin tick(); lat++; end
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    check("b_rd_lat", 64'(lat), 64'(3));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall%0d_rdata", k), rdata, 64'h8765_4321);
      check($sformatf("stall%0d_vr", k), 64'({rvalid, arready}), 64'(2'b10));
      tick();
    end
    rready = 1'b1;
    check("stall_arready_hs_cycle", 64'(arready), 64'(0));
    tick();
    check("stall_after_hs", 64'({rvalid, arready}), 64'(2'b01));
    sel = 1'b0;
    tick();

    // reset while both channels sit in their WAIT states
    awaddr = 32'h8000_0030; wdata = 64'h77; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0030; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", 64'({arready, awready, wready, rvalid, bvalid}), 64'(0));
    check("midrst_rdata", rdata, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_readies", 64'({arready, awready, wready}), 64'(3'b111));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("midrst_quiet%0d", k), 64'({rvalid, bvalid}), 64'(0));
      tick();
    end
    do_read(32'h8000_0030, 64'h66, 2'b00, lat);

    repeat (3) tick();
    check("rd_q_drained", 64'(rd_q.size()), 64'(0));
    check("b_q_drained",  64'(b_q.size()),  64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
